// File: rtl/line_buffer_pkg.sv
// line_buffer_pkg: shared widths, buffer-index type and read FSM states for line_buffer_ctrl.
package line_buffer_pkg;
   localparam int PIX_W    = 8;
   localparam int WIN_W    = 9 * PIX_W;
   localparam int NUM_BUFS = 4;
   typedef enum logic [0:0] {IDLE = 1'b0, READ = 1'b1} rd_state_t;
   typedef logic [1:0] buf_idx_t;
   function automatic logic [3:0] buf_onehot(buf_idx_t i);
      return 4'b0001 << i;
   endfunction
endpackage

// File: rtl/window_mux.sv
// window_mux: picks the three 24-bit tap groups starting at rd_sel; oldest line lands in the MSBs.
module window_mux
   import line_buffer_pkg::*;
#(
   parameter int NUM_BUFS = 4,
   parameter int PIX_W    = 8
) (
   input  buf_idx_t                     i_rd_sel,
   input  logic [NUM_BUFS*3*PIX_W-1:0]  i_lb_data,
   output logic [9*PIX_W-1:0]           o_win
);
   logic [3*PIX_W-1:0] taps [NUM_BUFS];
   buf_idx_t           sel_1;
   buf_idx_t           sel_2;
   for (genvar k = 0; k < NUM_BUFS; k++) begin : g_tap
      assign taps[k] = i_lb_data[k*3*PIX_W +: 3*PIX_W];
   end
   always_comb begin
      sel_1 = i_rd_sel + 2'd1;
      sel_2 = i_rd_sel + 2'd2;
      o_win = {taps[i_rd_sel], taps[sel_1], taps[sel_2]};
   end
endmodule

// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl: round-robin writes of raster lines into four line buffers and 3x3 window streaming.
// Define LINE_BUFFER_CTRL_FRAME_DONE_EN to add IMG_HEIGHT and the o_frame_done pulse.
module line_buffer_ctrl
   import line_buffer_pkg::*;
#(
   parameter int LINE_WIDTH = 512,
   parameter int NUM_BUFS   = 4,
   parameter int PIX_W      = 8
`ifdef LINE_BUFFER_CTRL_FRAME_DONE_EN
   ,
   parameter int IMG_HEIGHT = 512
`endif
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic [PIX_W-1:0]            i_pixel_data,
   input  logic                        i_pixel_data_valid,
   output logic [PIX_W-1:0]            o_lb_data,
   output logic [NUM_BUFS-1:0]         o_lb_wr_valid,
   output logic [NUM_BUFS-1:0]         o_lb_rd_en,
   input  logic [NUM_BUFS*3*PIX_W-1:0] i_lb_data,
   output logic [9*PIX_W-1:0]          o_window,
   output logic                        o_window_valid,
   output logic                        o_intr,
   output logic                        o_overflow
`ifdef LINE_BUFFER_CTRL_FRAME_DONE_EN
   ,
   output logic                        o_frame_done
`endif
);
   localparam int CW = $clog2(LINE_WIDTH);
   localparam int FW = $clog2(NUM_BUFS * LINE_WIDTH) + 1;
   localparam logic [FW-1:0] FILL_FULL  = FW'(NUM_BUFS * LINE_WIDTH);
   localparam logic [FW-1:0] FILL_START = FW'(3 * LINE_WIDTH);
   localparam logic [CW-1:0] PIX_LAST   = CW'(LINE_WIDTH - 1);

   rd_state_t            state_q, state_d;
   logic [CW-1:0]        wr_pix_cnt_q, wr_pix_cnt_d;
   logic [CW-1:0]        rd_pix_cnt_q, rd_pix_cnt_d;
   buf_idx_t             wr_sel_q, wr_sel_d;
   buf_idx_t             rd_sel_q, rd_sel_d;
   logic [FW-1:0]        fill_cnt_q, fill_cnt_d;
   logic [9*PIX_W-1:0]   window_q, window_d;
   logic                 window_valid_q, window_valid_d;
   logic                 intr_q, intr_d;
   logic                 overflow_q, overflow_d;
   logic [9*PIX_W-1:0]   win_sel;
   logic                 full;
   logic                 wr_ok;
   logic                 rd_act;
   logic                 line_end;

   window_mux #(
      .NUM_BUFS (NUM_BUFS),
      .PIX_W    (PIX_W)
   ) u_window_mux (
      .i_rd_sel  (rd_sel_q),
      .i_lb_data (i_lb_data),
      .o_win     (win_sel)
   );

   always_comb begin
      full           = fill_cnt_q == FILL_FULL;
      wr_ok          = i_pixel_data_valid && !full;
      rd_act         = state_q == READ;
      line_end       = rd_act && rd_pix_cnt_q == PIX_LAST;
      wr_pix_cnt_d   = wr_pix_cnt_q + CW'(wr_ok);
      wr_sel_d       = (wr_ok && wr_pix_cnt_q == PIX_LAST) ? wr_sel_q + 2'd1 : wr_sel_q;
      // a write and a read in the same cycle cancel out
      fill_cnt_d     = fill_cnt_q + FW'(wr_ok) - FW'(rd_act);
      state_d        = rd_act ? (line_end ? IDLE : READ) : (fill_cnt_q >= FILL_START ? READ : IDLE);
      rd_pix_cnt_d   = rd_act ? rd_pix_cnt_q + CW'(1) : '0;
      rd_sel_d       = line_end ? rd_sel_q + 2'd1 : rd_sel_q;
      intr_d         = line_end;
      overflow_d     = overflow_q || (i_pixel_data_valid && full);
      window_d       = rd_act ? win_sel : window_q;
      window_valid_d = rd_act;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q        <= IDLE;
         wr_pix_cnt_q   <= '0;
         rd_pix_cnt_q   <= '0;
         wr_sel_q       <= '0;
         rd_sel_q       <= '0;
         fill_cnt_q     <= '0;
         window_q       <= '0;
         window_valid_q <= 1'b0;
         intr_q         <= 1'b0;
         overflow_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         wr_pix_cnt_q   <= wr_pix_cnt_d;
         rd_pix_cnt_q   <= rd_pix_cnt_d;
         wr_sel_q       <= wr_sel_d;
         rd_sel_q       <= rd_sel_d;
         fill_cnt_q     <= fill_cnt_d;
         window_q       <= window_d;
         window_valid_q <= window_valid_d;
         intr_q         <= intr_d;
         overflow_q     <= overflow_d;
      end
   end

   // the buffer at rd_sel+3 is the only one not being read
   assign o_lb_data      = i_pixel_data;
   assign o_lb_wr_valid  = wr_ok ? NUM_BUFS'(buf_onehot(wr_sel_q)) : '0;
   assign o_lb_rd_en     = rd_act ? NUM_BUFS'(~buf_onehot(rd_sel_q + 2'd3)) : '0;
   assign o_window       = window_q;
   assign o_window_valid = window_valid_q;
   assign o_intr         = intr_q;
   assign o_overflow     = overflow_q;

`ifdef LINE_BUFFER_CTRL_FRAME_DONE_EN
   localparam int LCW = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
   logic [LCW-1:0] line_cnt_q, line_cnt_d;
   logic           frame_done_q, frame_done_d;
   logic           frame_hit;
   always_comb begin
      frame_hit    = line_end && line_cnt_q == LCW'(IMG_HEIGHT - 3);
      frame_done_d = frame_hit;
      line_cnt_d   = frame_hit ? '0 : (line_end ? line_cnt_q + LCW'(1) : line_cnt_q);
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         line_cnt_q   <= '0;
         frame_done_q <= 1'b0;
      end else begin
         line_cnt_q   <= line_cnt_d;
         frame_done_q <= frame_done_d;
      end
   end
   assign o_frame_done = frame_done_q;
`endif
endmodule
